mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the pipelined core and the memory. It serialises accesses with a fixed data-over-fetch priority and returns a one-cycle acknowledge per request, which the core uses to stall. A watchdog bounds every memory transaction.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_ifetch_buf.sv | 40 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State encoding, watchdog counter width, timed-out read data.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  localparam int CNT_W = 8;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/arb_ifetch_buf.sv
// Single-entry fetch buffer: valid/tag/data, hit compare, fill, inval.
// Ports: look_addr->hit/hit_data, fill_*, wr_grant/wr_addr invalidate.
module arb_ifetch_buf #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          wr_grant,
  input  logic [AW-1:0] wr_addr
);

  logic          vld;
  logic [AW-1:0] tag;
  logic [DW-1:0] data;

  assign hit      = vld && (tag == look_addr);
  assign hit_data = data;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld  <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (fill) begin
      vld  <= 1'b1;
      tag  <= fill_addr;
      data <= fill_data;
    end else if (wr_grant && (wr_addr == tag)) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one variable-latency memory, data priority.
// Ports: if_*, d_* requesters; m_* memory; err on watchdog timeout.
// Option: MEM_ARB_IFETCH_BUF_EN adds a one-entry fetch buffer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy, tmo, fin;
  logic             hit, fill, wr_grant;
  logic [DW-1:0]    hit_data, end_data;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // m_ack in the timeout cycle wins, so tmo needs !m_ack
  assign tmo = busy && !m_ack && (TIMEOUT != 0) &&
               ((32'(cnt) + 32'd1) == TIMEOUT);
  assign fin = m_ack || tmo;

  assign end_data = m_ack ? m_rdata : DW'(ERR_RDATA);
  assign fill     = (state == BUSY_I) && m_ack;
  assign wr_grant = (state == IDLE) && d_req && d_wr;

`ifdef MEM_ARB_IFETCH_BUF_EN
  arb_ifetch_buf #(.AW(AW), .DW(DW)) u_buf (
    .clk       (clk),
    .nrst      (nrst),
    .look_addr (if_addr),
    .hit       (hit),
    .hit_data  (hit_data),
    .fill      (fill),
    .fill_addr (m_addr),
    .fill_data (m_rdata),
    .wr_grant  (wr_grant),
    .wr_addr   (d_addr)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (d_req)       state_nxt = BUSY_D;
        else if (if_req) state_nxt = hit ? DONE_I : BUSY_I;
      end
      BUSY_I: if (fin) state_nxt = DONE_I;
      BUSY_D: if (fin) state_nxt = DONE_D;
      DONE_I: state_nxt = IDLE;
      DONE_D: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      m_req    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      cnt    <= busy ? cnt + 1'b1 : '0;
      m_req  <= (state_nxt == BUSY_I) ||
                (state_nxt == BUSY_D);
      if_ack <= (state_nxt == DONE_I);
      d_ack  <= (state_nxt == DONE_D);
      err    <= tmo;
      if (state == IDLE) begin
        if (d_req) begin
          m_wr    <= d_wr;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else if (if_req && hit) begin
          if_rdata <= hit_data;
        end else if (if_req) begin
          m_wr   <= 1'b0;
          m_addr <= if_addr;
        end
      end
      if ((state == BUSY_I) && fin) if_rdata <= end_data;
      if ((state == BUSY_D) && fin) d_rdata  <= end_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, TIMEOUT=4, bench drives m_ack.
// Steps are linear; buffer steps compile only with the option macro.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        m_req;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .err      (err),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_wr", 32'(m_wr), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    nrst = 1'b1;
    tick;

    // fetch alone, L=3
    if_req = 1'b1; if_addr = 32'h40;
    tick;
    chk("f_m_req1", 32'(m_req), 32'd1);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_wr", 32'(m_wr), 32'd0);
    tick;
    chk("f_m_req2", 32'(m_req), 32'd1);
    chk("f_no_ack2", 32'(if_ack), 32'd0);
    tick;
    chk("f_m_req3", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h8C010004;
    tick;
    m_ack = 1'b0; if_req = 1'b0;
    chk("f_if_ack", 32'(if_ack), 32'd1);
    chk("f_if_rdata", if_rdata, 32'h8C010004);
    chk("f_err", 32'(err), 32'd0);
    chk("f_m_req_low", 32'(m_req), 32'd0);
    tick;
    chk("f_ack_pulse", 32'(if_ack), 32'd0);

    // simultaneous: data write first, then fetch with L=2
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_wr = 1'b1;
    d_addr = 32'h100; d_wdata = 32'h1234;
    tick;
    chk("s_m_wr", 32'(m_wr), 32'd1);
    chk("s_m_addr", m_addr, 32'h100);
    chk("s_m_wdata", m_wdata, 32'h1234);
    m_ack = 1'b1; m_rdata = 32'hDEAD;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    chk("s_d_ack", 32'(d_ack), 32'd1);
    chk("s_if_ack_not", 32'(if_ack), 32'd0);
    tick;
    chk("s_idle_m_req", 32'(m_req), 32'd0);
    chk("s_idle_d_ack", 32'(d_ack), 32'd0);
    tick;
    chk("s_f_m_req", 32'(m_req), 32'd1);
    chk("s_f_m_addr", m_addr, 32'h80);
    chk("s_f_m_wr", 32'(m_wr), 32'd0);
    tick;
    chk("s_f_m_req2", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h13;
    tick;
    m_ack = 1'b0; if_req = 1'b0;
    chk("s_if_ack", 32'(if_ack), 32'd1);
    chk("s_if_rdata", if_rdata, 32'h13);
    tick;

    // timeout: memory never acks
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
    tick;
    chk("t_m_addr", m_addr, 32'h200);
    for (int i = 0; i < 4; i++) begin
      chk("t_m_req", 32'(m_req), 32'd1);
      chk("t_no_ack", 32'(d_ack), 32'd0);
      tick;
    end
    d_req = 1'b0;
    chk("t_d_ack", 32'(d_ack), 32'd1);
    chk("t_err", 32'(err), 32'd1);
    chk("t_d_rdata", d_rdata, 32'd0);
    chk("t_m_req_low", 32'(m_req), 32'd0);
    tick;
    chk("t_err_pulse", 32'(err), 32'd0);
    chk("t_ack_pulse", 32'(d_ack), 32'd0);

    // m_ack coincident with timeout cycle
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h204;
    tick;
    tick;
    tick;
    tick;
    chk("c_m_req4", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h55;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    chk("c_d_ack", 32'(d_ack), 32'd1);
    chk("c_err", 32'(err), 32'd0);
    chk("c_d_rdata", d_rdata, 32'h55);
    tick;

    // stray m_ack in IDLE
    m_ack = 1'b1; m_rdata = 32'hFFFF;
    tick;
    m_ack = 1'b0;
    chk("l_m_req", 32'(m_req), 32'd0);
    chk("l_if_ack", 32'(if_ack), 32'd0);
    chk("l_d_ack", 32'(d_ack), 32'd0);
    chk("l_err", 32'(err), 32'd0);
    tick;
    chk("l_m_req2", 32'(m_req), 32'd0);

    // back-to-back: held d_req is re-arbitrated
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h500;
    tick;
    m_ack = 1'b1; m_rdata = 32'h61;
    tick;
    m_ack = 1'b0;
    chk("b_d_ack1", 32'(d_ack), 32'd1);
    chk("b_d_rdata1", d_rdata, 32'h61);
    tick;
    chk("b_idle_m_req", 32'(m_req), 32'd0);
    tick;
    chk("b_m_req2", 32'(m_req), 32'd1);
    chk("b_m_addr2", m_addr, 32'h500);
    m_ack = 1'b1; m_rdata = 32'h62;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    chk("b_d_ack2", 32'(d_ack), 32'd1);
    chk("b_d_rdata2", d_rdata, 32'h62);
    tick;

    // async reset during BUSY_D
    d_req = 1'b1; d_wr = 1'b1;
    d_addr = 32'h300; d_wdata = 32'hAA;
    tick;
    chk("r_m_req_pre", 32'(m_req), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("r_m_req_drop", 32'(m_req), 32'd0);
    d_req = 1'b0;
    tick;
    nrst = 1'b1;
    if_req = 1'b1; if_addr = 32'h44;
    tick;
    chk("r_f_m_req", 32'(m_req), 32'd1);
    chk("r_f_m_addr", m_addr, 32'h44);
    chk("r_f_m_wr", 32'(m_wr), 32'd0);
    m_ack = 1'b1; m_rdata = 32'h77;
    tick;
    m_ack = 1'b0; if_req = 1'b0;
    chk("r_if_ack", 32'(if_ack), 32'd1);
    chk("r_if_rdata", if_rdata, 32'h77);
    tick;

`ifdef MEM_ARB_IFETCH_BUF_EN
    // buffer hit: 0x44 was just filled
    if_req = 1'b1; if_addr = 32'h44;
    tick;
    if_req = 1'b0;
    chk("h_if_ack", 32'(if_ack), 32'd1);
    chk("h_if_rdata", if_rdata, 32'h77);
    chk("h_no_m_req", 32'(m_req), 32'd0);
    tick;
    // write to the tag invalidates
    d_req = 1'b1; d_wr = 1'b1;
    d_addr = 32'h44; d_wdata = 32'h9;
    tick;
    m_ack = 1'b1; m_rdata = 32'h0;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    chk("h_w_ack", 32'(d_ack), 32'd1);
    tick;
    if_req = 1'b1; if_addr = 32'h44;
    tick;
    chk("h_miss_m_req", 32'(m_req), 32'd1);
    chk("h_miss_no_ack", 32'(if_ack), 32'd0);
    m_ack = 1'b1; m_rdata = 32'h99;
    tick;
    m_ack = 1'b0; if_req = 1'b0;
    chk("h_miss_ack", 32'(if_ack), 32'd1);
    chk("h_miss_rdata", if_rdata, 32'h99);
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
